cp0_exc_ctrl: RTL and testbench

//  Exception/interrupt sequencer for the CP0 register file. Samples exception flags of the

---
 rtl/cp0_exc_ctrl.sv | 266 ++++++++++++++++++++++++++
 tb/tb_cp0_exc_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exc_ctrl.sv
// ============================================================================
// cp0_exc_ctrl
// ----------------------------------------------------------------------------
// Exception / interrupt sequencer sitting between the MEM stage and CP0/PC.
// It watches the exception flags of the instruction in MEM and the pending
// interrupt condition, picks one cause by fixed priority, then:
//   - emits a single-cycle excepttype pulse (with pc / delay-slot / bad
//     address) to CP0,
//   - raises flush with the redirect PC in that same cycle,
//   - holds off any further event for DRAIN_CYCLES cycles while the
//     pipeline empties.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   mem_valid_i              MEM holds a real instruction
//   mem_pc_i                 PC of the MEM instruction
//   mem_in_delayslot_i       MEM instruction sits in a branch delay slot
//   mem_bad_addr_i           faulting data address of a MEM load/store
//   exc_*_i, eret_i          per-instruction exception / ERET flags
//   int_i[5:0]               asynchronous hardware interrupt lines
//   status_i/cause_i/epc_i   current CP0 register contents
//   wb_cp0_*_i               MTC0 write happening in WB this cycle
//   excepttype_o             cause code to CP0 (0 when idle)
//   exc_pc_o                 faulting instruction address to CP0
//   exc_delayslot_o          delay-slot flag to CP0
//   exc_bad_addr_o           BadVAddr value to CP0
//   flush_o / new_pc_o       pipeline flush and redirect target
//   busy_o                   sequencer is committing or draining
// ============================================================================
module cp0_exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter int          DRAIN_CYCLES = 2,
    parameter int          SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delayslot_i,
    input  logic [31:0] mem_bad_addr_i,
    input  logic        exc_if_adel_i,
    input  logic        exc_ri_i,
    input  logic        exc_ov_i,
    input  logic        exc_sys_i,
    input  logic        exc_bp_i,
    input  logic        exc_adel_i,
    input  logic        exc_ades_i,
    input  logic        eret_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_data_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] exc_pc_o,
    output logic        exc_delayslot_o,
    output logic [31:0] exc_bad_addr_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        busy_o
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [4:0] ADDR_STATUS = 5'd12;
    localparam logic [4:0] ADDR_CAUSE  = 5'd13;
    localparam logic [4:0] ADDR_EPC    = 5'd14;

    localparam logic [31:0] EXC_NONE = 32'h0000_0000;
    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
    localparam logic [31:0] EXC_ADES = 32'h0000_0005;
    localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_BP   = 32'h0000_0009;
    localparam logic [31:0] EXC_RI   = 32'h0000_000A;
    localparam logic [31:0] EXC_OV   = 32'h0000_000C;
    localparam logic [31:0] EXC_ERET = 32'h0000_000E;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COMMIT = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        type_q, type_d;
    logic [31:0]        pc_q, pc_d;
    logic               ds_q, ds_d;
    logic [31:0]        bad_q, bad_d;
    logic               flush_q, flush_d;
    logic [31:0]        new_pc_q, new_pc_d;
    logic               busy_q, busy_d;

    logic [5:0]         sync_q [SYNC_STAGES];

    logic [31:0]        status_fwd_s;
    logic [31:0]        epc_fwd_s;
    logic [1:0]         cause_sw_s;
    logic [7:0]         int_vec_s;
    logic               int_pend_s;
    logic [31:0]        cand_type_s;
    logic [31:0]        cand_bad_s;
    logic               cand_hit_s;
    logic               unused_s;

    // Interrupt line synchronizer; only the last stage feeds the logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= 6'b00_0000;
            end
        end else begin
            sync_q[0] <= int_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // WB->CP0 bypass so an MTC0 in the same cycle is honoured immediately.
    // Only the software interrupt bits of CAUSE are writable, hence [9:8].
    always_comb begin
        if (wb_cp0_we_i && (wb_cp0_waddr_i == ADDR_STATUS)) begin
            status_fwd_s = wb_cp0_data_i;
        end else begin
            status_fwd_s = status_i;
        end
        if (wb_cp0_we_i && (wb_cp0_waddr_i == ADDR_EPC)) begin
            epc_fwd_s = wb_cp0_data_i;
        end else begin
            epc_fwd_s = epc_i;
        end
        if (wb_cp0_we_i && (wb_cp0_waddr_i == ADDR_CAUSE)) begin
            cause_sw_s = wb_cp0_data_i[9:8];
        end else begin
            cause_sw_s = cause_i[9:8];
        end
    end

    // Interrupt pending: masked lines, global enable set, not already at EXL.
    always_comb begin
        int_vec_s  = {sync_q[SYNC_STAGES-1], cause_sw_s};
        int_pend_s = (|(int_vec_s & status_fwd_s[15:8])) &&
                     status_fwd_s[0] && !status_fwd_s[1];
    end

    // Priority pick of a single cause and its bad address.
    always_comb begin
        cand_type_s = EXC_NONE;
        cand_bad_s  = 32'h0000_0000;
        if (int_pend_s) begin
            cand_type_s = EXC_INT;
        end else if (exc_if_adel_i) begin
            cand_type_s = EXC_ADEL;
            cand_bad_s  = mem_pc_i;
        end else if (exc_ri_i) begin
            cand_type_s = EXC_RI;
        end else if (exc_ov_i) begin
            cand_type_s = EXC_OV;
        end else if (exc_sys_i) begin
            cand_type_s = EXC_SYS;
        end else if (exc_bp_i) begin
            cand_type_s = EXC_BP;
        end else if (exc_adel_i) begin
            cand_type_s = EXC_ADEL;
            cand_bad_s  = mem_bad_addr_i;
        end else if (exc_ades_i) begin
            cand_type_s = EXC_ADES;
            cand_bad_s  = mem_bad_addr_i;
        end else if (eret_i) begin
            cand_type_s = EXC_ERET;
        end else begin
            cand_type_s = EXC_NONE;
        end
        cand_hit_s = (state_q == S_IDLE) && mem_valid_i && (cand_type_s != EXC_NONE);
    end

    // Next-state and next-output logic. Outputs are only nonzero in the
    // cycle the FSM sits in COMMIT, because they are loaded on the
    // IDLE->COMMIT transition and cleared on every other transition.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        type_d   = EXC_NONE;
        pc_d     = 32'h0000_0000;
        ds_d     = 1'b0;
        bad_d    = 32'h0000_0000;
        flush_d  = 1'b0;
        new_pc_d = 32'h0000_0000;
        case (state_q)
            S_IDLE: begin
                if (cand_hit_s) begin
                    state_d = S_COMMIT;
                    type_d  = cand_type_s;
                    pc_d    = mem_pc_i;
                    ds_d    = mem_in_delayslot_i;
                    bad_d   = cand_bad_s;
                    flush_d = 1'b1;
                    if (cand_type_s == EXC_ERET) begin
                        new_pc_d = epc_fwd_s;
                    end else begin
                        new_pc_d = EXC_VECTOR;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_COMMIT: begin
                state_d = S_DRAIN;
                cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
            end
            S_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            type_q   <= EXC_NONE;
            pc_q     <= 32'h0000_0000;
            ds_q     <= 1'b0;
            bad_q    <= 32'h0000_0000;
            flush_q  <= 1'b0;
            new_pc_q <= 32'h0000_0000;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            type_q   <= type_d;
            pc_q     <= pc_d;
            ds_q     <= ds_d;
            bad_q    <= bad_d;
            flush_q  <= flush_d;
            new_pc_q <= new_pc_d;
            busy_q   <= busy_d;
        end
    end

    assign excepttype_o    = type_q;
    assign exc_pc_o        = pc_q;
    assign exc_delayslot_o = ds_q;
    assign exc_bad_addr_o  = bad_q;
    assign flush_o         = flush_q;
    assign new_pc_o        = new_pc_q;
    assign busy_o          = busy_q;

    // Register bits that this block never looks at.
    assign unused_s = ^{status_fwd_s[31:16], status_fwd_s[7:2],
                        cause_i[31:10], cause_i[7:0]};

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
module tb_cp0_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid_i;
    logic [31:0] mem_pc_i;
    logic        mem_in_delayslot_i;
    logic [31:0] mem_bad_addr_i;
    logic        exc_if_adel_i, exc_ri_i, exc_ov_i, exc_sys_i, exc_bp_i;
    logic        exc_adel_i, exc_ades_i, eret_i;
    logic [5:0]  int_i;
    logic [31:0] status_i, cause_i, epc_i;
    logic        wb_cp0_we_i;
    logic [4:0]  wb_cp0_waddr_i;
    logic [31:0] wb_cp0_data_i;
    logic [31:0] excepttype_o, exc_pc_o, exc_bad_addr_o, new_pc_o;
    logic        exc_delayslot_o, flush_o, busy_o;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] VEC = 32'hBFC0_0380;

    cp0_exc_ctrl dut (
        .clk(clk), .rst(rst),
        .mem_valid_i(mem_valid_i), .mem_pc_i(mem_pc_i),
        .mem_in_delayslot_i(mem_in_delayslot_i), .mem_bad_addr_i(mem_bad_addr_i),
        .exc_if_adel_i(exc_if_adel_i), .exc_ri_i(exc_ri_i), .exc_ov_i(exc_ov_i),
        .exc_sys_i(exc_sys_i), .exc_bp_i(exc_bp_i), .exc_adel_i(exc_adel_i),
        .exc_ades_i(exc_ades_i), .eret_i(eret_i), .int_i(int_i),
        .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i),
        .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i),
        .wb_cp0_data_i(wb_cp0_data_i),
        .excepttype_o(excepttype_o), .exc_pc_o(exc_pc_o),
        .exc_delayslot_o(exc_delayslot_o), .exc_bad_addr_o(exc_bad_addr_o),
        .flush_o(flush_o), .new_pc_o(new_pc_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] bad;
        logic [6:0]  exc;     // {if_adel, ri, ov, sys, bp, adel, ades}
        logic        eret;
        logic [31:0] status;
        logic [31:0] cause;
        logic [31:0] epc;
        logic        wb_we;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic [31:0] e_type;
        logic [31:0] e_bad;
        logic [31:0] e_newpc;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        mem_valid_i = 1'b0; mem_pc_i = 32'h0; mem_in_delayslot_i = 1'b0;
        mem_bad_addr_i = 32'h0;
        {exc_if_adel_i, exc_ri_i, exc_ov_i, exc_sys_i, exc_bp_i, exc_adel_i, exc_ades_i} = 7'b0;
        eret_i = 1'b0; int_i = 6'b0;
        status_i = 32'h0; cause_i = 32'h0; epc_i = 32'h0;
        wb_cp0_we_i = 1'b0; wb_cp0_waddr_i = 5'd0; wb_cp0_data_i = 32'h0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".type"},   excepttype_o, 32'h0);
        chk({tag, ".pc"},     exc_pc_o, 32'h0);
        chk({tag, ".ds"},     {31'b0, exc_delayslot_o}, 32'h0);
        chk({tag, ".bad"},    exc_bad_addr_o, 32'h0);
        chk({tag, ".flush"},  {31'b0, flush_o}, 32'h0);
        chk({tag, ".newpc"},  new_pc_o, 32'h0);
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 10 && busy_o; k++) step();
        chk({tag, ".idle_timeout"}, {31'b0, busy_o}, 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        //              valid pc            ds    bad           exc         eret  status        cause         epc           we    addr   wbdata        type          bad           newpc
        vecs[0]  = '{1'b1, 32'h8000_0020, 1'b0, 32'h0000_1234, 7'b0110010, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0, 5'd0,  32'h0,        32'hA,        32'h0,        VEC};
        vecs[1]  = '{1'b1, 32'h8000_0030, 1'b0, 32'h0000_0003, 7'b0000001, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0, 5'd0,  32'h0,        32'h5,        32'h3,        VEC};
        vecs[2]  = '{1'b1, 32'h8000_0040, 1'b0, 32'h0,         7'b0000000, 1'b1, 32'h0,        32'h0,        32'h0,        1'b1, 5'd14, 32'h8000_1000, 32'hE,        32'h0,        32'h8000_1000};
        vecs[3]  = '{1'b1, 32'h8000_0041, 1'b0, 32'h0000_7777, 7'b1100000, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0, 5'd0,  32'h0,        32'h4,        32'h8000_0041, VEC};
        vecs[4]  = '{1'b1, 32'h8000_0050, 1'b1, 32'h0,         7'b0001100, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0, 5'd0,  32'h0,        32'h8,        32'h0,        VEC};
        vecs[5]  = '{1'b1, 32'h8000_0054, 1'b0, 32'h0,         7'b0000100, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0, 5'd0,  32'h0,        32'h9,        32'h0,        VEC};
        vecs[6]  = '{1'b1, 32'h8000_0058, 1'b1, 32'h0,         7'b0011000, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0, 5'd0,  32'h0,        32'hC,        32'h0,        VEC};
        vecs[7]  = '{1'b1, 32'h8000_005C, 1'b0, 32'h0000_0055, 7'b0000011, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0, 5'd0,  32'h0,        32'h4,        32'h0000_0055, VEC};
        vecs[8]  = '{1'b1, 32'h8000_0060, 1'b0, 32'h0,         7'b0000000, 1'b1, 32'h0,        32'h0,        32'h8000_2000, 1'b1, 5'd12, 32'h0,        32'hE,        32'h0,        32'h8000_2000};
        vecs[9]  = '{1'b0, 32'h8000_0064, 1'b0, 32'h0,         7'b0001000, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0, 5'd0,  32'h0,        32'h0,        32'h0,        32'h0};
        vecs[10] = '{1'b1, 32'h8000_0068, 1'b0, 32'h0,         7'b0001000, 1'b1, 32'h0,        32'h0,        32'h8000_3000, 1'b0, 5'd0,  32'h0,        32'h8,        32'h0,        VEC};
        vecs[11] = '{1'b1, 32'h8000_006C, 1'b0, 32'h0,         7'b0000000, 1'b0, 32'h0000_0101, 32'h0,       32'h0,        1'b1, 5'd13, 32'h0000_0100, 32'h1,       32'h0,        VEC};
        vecs[12] = '{1'b1, 32'h8000_0070, 1'b1, 32'h0,         7'b0000001, 1'b0, 32'h0,        32'h0000_0100, 32'h0,       1'b1, 5'd12, 32'h0000_0101, 32'h1,       32'h0,        VEC};
        vecs[13] = '{1'b1, 32'h8000_0074, 1'b0, 32'h0,         7'b0001000, 1'b0, 32'h0000_0301, 32'h0000_0300, 32'h0,      1'b1, 5'd13, 32'h0,        32'h8,        32'h0,        VEC};

        clear_inputs();
        do_reset();
        chk_quiet("reset");
        chk("reset.busy", {31'b0, busy_o}, 32'h0);

        // Table-driven single events
        for (int i = 0; i < 14; i++) begin
            mem_valid_i = vecs[i].valid; mem_pc_i = vecs[i].pc;
            mem_in_delayslot_i = vecs[i].ds; mem_bad_addr_i = vecs[i].bad;
            {exc_if_adel_i, exc_ri_i, exc_ov_i, exc_sys_i, exc_bp_i, exc_adel_i, exc_ades_i} = vecs[i].exc;
            eret_i = vecs[i].eret; status_i = vecs[i].status; cause_i = vecs[i].cause;
            epc_i = vecs[i].epc; wb_cp0_we_i = vecs[i].wb_we;
            wb_cp0_waddr_i = vecs[i].wb_addr; wb_cp0_data_i = vecs[i].wb_data;
            step();
            clear_inputs();
            if (vecs[i].e_type != 32'h0) begin
                chk($sformatf("v%0d.type", i), excepttype_o, vecs[i].e_type);
                chk($sformatf("v%0d.pc", i), exc_pc_o, vecs[i].pc);
                chk($sformatf("v%0d.ds", i), {31'b0, exc_delayslot_o}, {31'b0, vecs[i].ds});
                chk($sformatf("v%0d.bad", i), exc_bad_addr_o, vecs[i].e_bad);
                chk($sformatf("v%0d.flush", i), {31'b0, flush_o}, 32'h1);
                chk($sformatf("v%0d.newpc", i), new_pc_o, vecs[i].e_newpc);
                chk($sformatf("v%0d.busy", i), {31'b0, busy_o}, 32'h1);
                step();
                chk_quiet($sformatf("v%0d.drain", i));
                chk($sformatf("v%0d.drain_busy", i), {31'b0, busy_o}, 32'h1);
                wait_idle($sformatf("v%0d", i));
            end else begin
                chk_quiet($sformatf("v%0d.none", i));
                chk($sformatf("v%0d.none_busy", i), {31'b0, busy_o}, 32'h0);
            end
        end

        // Interrupt through the synchronizer: pulse after SYNC_STAGES+1 edges
        do_reset();
        int_i = 6'b00_0001; status_i = 32'h0000_0401;
        mem_valid_i = 1'b1; mem_pc_i = 32'h8000_0010;
        step();
        chk("int.e1.type", excepttype_o, 32'h0);
        step();
        chk("int.e2.type", excepttype_o, 32'h0);
        chk("int.e2.busy", {31'b0, busy_o}, 32'h0);
        step();
        chk("int.type", excepttype_o, 32'h1);
        chk("int.pc", exc_pc_o, 32'h8000_0010);
        chk("int.flush", {31'b0, flush_o}, 32'h1);
        chk("int.newpc", new_pc_o, VEC);
        clear_inputs();
        step();
        chk("int.onecycle", excepttype_o, 32'h0);
        wait_idle("int");

        // Held ADES: ignored in DRAIN, re-detected at earliest legal cycle
        mem_valid_i = 1'b1; mem_pc_i = 32'h8000_0080;
        exc_ades_i = 1'b1; mem_bad_addr_i = 32'h0000_0003;
        begin
            logic [31:0] exp_t [5];
            logic        exp_b [5];
            exp_t[0] = 32'h5; exp_t[1] = 32'h0; exp_t[2] = 32'h0; exp_t[3] = 32'h0; exp_t[4] = 32'h5;
            exp_b[0] = 1'b1;  exp_b[1] = 1'b1;  exp_b[2] = 1'b1;  exp_b[3] = 1'b0;  exp_b[4] = 1'b1;
            for (int k = 0; k < 5; k++) begin
                step();
                chk($sformatf("hold.e%0d.type", k), excepttype_o, exp_t[k]);
                chk($sformatf("hold.e%0d.busy", k), {31'b0, busy_o}, {31'b0, exp_b[k]});
                if (k == 0) chk("hold.bad", exc_bad_addr_o, 32'h3);
            end
        end
        clear_inputs();
        wait_idle("hold");

        // Pending interrupt blocked by EXL, taken once EXL clears
        int_i = 6'b00_0001; status_i = 32'h0000_0403;
        mem_valid_i = 1'b1; mem_pc_i = 32'h8000_0090;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("exl.e%0d.busy", k), {31'b0, busy_o}, 32'h0);
        end
        status_i = 32'h0000_0401;
        step();
        chk("exl.taken.type", excepttype_o, 32'h1);
        chk("exl.taken.pc", exc_pc_o, 32'h8000_0090);
        clear_inputs();
        wait_idle("exl");

        // Reset during COMMIT aborts immediately
        mem_valid_i = 1'b1; mem_pc_i = 32'h8000_00A0; exc_sys_i = 1'b1;
        step();
        chk("rstc.type", excepttype_o, 32'h8);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_quiet("rstc.after");
        chk("rstc.busy", {31'b0, busy_o}, 32'h0);
        step();
        chk("rstc.fresh.type", excepttype_o, 32'h8);
        chk("rstc.fresh.pc", exc_pc_o, 32'h8000_00A0);
        clear_inputs();
        wait_idle("rstc");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
